// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared opcodes, flag values, exception codes and decode helpers
// Purpose: opcode map and small decode functions shared by the MEM stage and its lane aligner.
// Ports: none (package).
package mem_access_unit_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2b;
  localparam logic [5:0] OP_LL  = 6'h30;
  localparam logic [5:0] OP_SC  = 6'h38;

  localparam logic RAM_WRITE   = 1'b1;
  localparam logic RAM_READ    = 1'b0;
  localparam logic RAM_ENABLE  = 1'b1;
  localparam logic RAM_DISABLE = 1'b0;
  localparam logic SET_FLAG    = 1'b1;
  localparam logic CLEAR_FLAG  = 1'b0;

  typedef enum logic [1:0] {
    EXC_NONE      = 2'd0,
    EXC_MIS_LOAD  = 2'd1,
    EXC_MIS_STORE = 2'd2,
    EXC_TIMEOUT   = 2'd3
  } excp_code_e;

  typedef enum logic {S_IDLE, S_ACCESS} state_e;

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
           (op == OP_LHU) || (op == OP_LW) || (op == OP_LL);
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW) || (op == OP_SC);
  endfunction

  function automatic logic is_mem(input logic [5:0] op);
    return is_load(op) || is_store(op);
  endfunction

  // Halves need even addresses; words (including LL/SC) need 4-byte alignment.
  function automatic logic misaligned(input logic [5:0] op, input logic [1:0] lo);
    if ((op == OP_LH) || (op == OP_LHU) || (op == OP_SH))
      return lo[0];
    if ((op == OP_LW) || (op == OP_SW) || (op == OP_LL) || (op == OP_SC))
      return lo != 2'b00;
    return 1'b0;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - req/ack data-memory port
// Purpose: groups the data-memory bus; master = MEM stage, slave = memory.
// Signals: ce request, we write, be byte enables, addr word address, wdata lane-aligned
//          store data, rdata read data (valid with ack), ack access complete.
interface mem_access_unit_if #(parameter int ADDR_W = 32);
  logic              ce;
  logic              we;
  logic [3:0]        be;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              ack;

  modport master (output ce, we, be, addr, wdata, input rdata, ack);
  modport slave  (input ce, we, be, addr, wdata, output rdata, ack);
endinterface

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - store lane placement and load lane extraction
// Purpose: combinational byte-enable / write-data generation for stores and
//          lane select plus sign/zero extension for loads, by op and addr[1:0].
// Ports: op, lo (addr[1:0]), wdata (rt), rdata (memory word) in;
//        be, wdata_lane, load_data out.
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [1:0]  lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] load_data
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic [3:0]  be_byte;
  logic [3:0]  be_half;

  always_comb begin
    rbyte      = rdata[{lo, 3'b000} +: 8];
    rhalf      = lo[1] ? rdata[31:16] : rdata[15:0];
    be_byte    = 4'b0001 << lo;
    be_half    = lo[1] ? 4'b1100 : 4'b0011;
    be         = 4'b1111;
    wdata_lane = wdata;
    load_data  = rdata;
    case (op)
      OP_SB: begin
        be         = be_byte;
        wdata_lane = {4{wdata[7:0]}};
      end
      OP_SH: begin
        be         = be_half;
        wdata_lane = {2{wdata[15:0]}};
      end
      OP_LB: begin
        be        = be_byte;
        load_data = {{24{rbyte[7]}}, rbyte};
      end
      OP_LBU: begin
        be        = be_byte;
        load_data = {24'h0, rbyte};
      end
      OP_LH: begin
        be        = be_half;
        load_data = {{16{rhalf[15]}}, rhalf};
      end
      OP_LHU: begin
        be        = be_half;
        load_data = {16'h0, rhalf};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM pipeline stage: loads, stores, LL/SC over a req/ack port
// Purpose: runs byte/half/word loads and stores plus LL/SC, stalls upstream until the
//          memory acks or times out, owns the LL reservation, flags misalignment/timeouts.
// Ports: clk, rst (async, active-high); valid_i/op_i/addr_i/wdata_i/regc_* from EX/MEM;
//        llbit_clr_i clears the reservation; stall_o holds upstream; wb_valid_o, reg_*,
//        excp_o, excp_code_o to WB; mem (master) is the data-memory port.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16,
  parameter bit LLSC_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [5:0]        op_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  input  logic [4:0]        regc_addr_i,
  input  logic              regc_wr_i,
  input  logic [31:0]       regc_data_i,
  input  logic              llbit_clr_i,
  output logic              stall_o,
  output logic              wb_valid_o,
  output logic [4:0]        reg_addr_o,
  output logic              reg_wr_o,
  output logic [31:0]       reg_data_o,
  output logic              excp_o,
  output logic [1:0]        excp_code_o,
  mem_access_unit_if.master mem
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e            state, state_n;
  logic [TW-1:0]     tmo_cnt;
  logic              llbit;
  logic [ADDR_W-3:0] ll_addr;
  logic [5:0]        st_op;
  logic [1:0]        st_lo;
  logic [ADDR_W-3:0] st_word;
  logic [4:0]        st_dest;
  logic              st_wr;

  logic mem_op, misal, sc_fail, ack_hit, tmo_hit;
  logic [5:0]  lane_op;
  logic [1:0]  lane_lo;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata, lane_load;

  // One aligner serves both directions: IDLE uses it for the incoming store,
  // ACCESS uses it on the latched op to extract the returned load data.
  assign lane_op = (state == S_ACCESS) ? st_op : op_i;
  assign lane_lo = (state == S_ACCESS) ? st_lo : addr_i[1:0];

  mem_lane_align u_lane (
    .op         (lane_op),
    .lo         (lane_lo),
    .wdata      (wdata_i),
    .rdata      (mem.rdata),
    .be         (lane_be),
    .wdata_lane (lane_wdata),
    .load_data  (lane_load)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Stall drops in the completing ACCESS cycle so the held instruction retires
  // on the same edge the result is registered, and is not re-issued.
  always_comb begin
    state_n = state;
    stall_o = 1'b0;
    ack_hit = 1'b0;
    tmo_hit = 1'b0;
    mem_op  = is_mem(op_i);
    misal   = misaligned(op_i, addr_i[1:0]);
    sc_fail = (op_i == OP_SC) &&
              !(LLSC_EN && llbit && (ll_addr == addr_i[ADDR_W-1:2]));
    case (state)
      S_IDLE: begin
        if (valid_i && mem_op && !misal && !sc_fail) begin
          stall_o = 1'b1;
          state_n = S_ACCESS;
        end
      end
      S_ACCESS: begin
        ack_hit = mem.ack;
        tmo_hit = (TIMEOUT != 0) && !mem.ack && (tmo_cnt == TMO_LAST);
        stall_o = !(ack_hit || tmo_hit);
        if (ack_hit || tmo_hit) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid_o  <= 1'b0;
      reg_addr_o  <= '0;
      reg_wr_o    <= 1'b0;
      reg_data_o  <= '0;
      excp_o      <= 1'b0;
      excp_code_o <= EXC_NONE;
      mem.ce      <= RAM_DISABLE;
      mem.we      <= RAM_READ;
      mem.be      <= '0;
      mem.addr    <= '0;
      mem.wdata   <= '0;
      tmo_cnt     <= '0;
      llbit       <= CLEAR_FLAG;
      ll_addr     <= '0;
      st_op       <= '0;
      st_lo       <= '0;
      st_word     <= '0;
      st_dest     <= '0;
      st_wr       <= 1'b0;
    end else begin
      wb_valid_o <= 1'b0;
      excp_o     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (valid_i) begin
            if (!mem_op) begin
              wb_valid_o  <= 1'b1;
              reg_addr_o  <= regc_addr_i;
              reg_wr_o    <= regc_wr_i;
              reg_data_o  <= regc_data_i;
              excp_code_o <= EXC_NONE;
            end else if (misal) begin
              wb_valid_o  <= 1'b1;
              excp_o      <= 1'b1;
              excp_code_o <= is_store(op_i) ? EXC_MIS_STORE : EXC_MIS_LOAD;
              reg_addr_o  <= regc_addr_i;
              reg_wr_o    <= 1'b0;
            end else if (sc_fail) begin
              wb_valid_o  <= 1'b1;
              reg_addr_o  <= regc_addr_i;
              reg_wr_o    <= regc_wr_i;
              reg_data_o  <= '0;
              excp_code_o <= EXC_NONE;
              llbit       <= CLEAR_FLAG;
            end else begin
              mem.ce    <= RAM_ENABLE;
              mem.we    <= is_store(op_i) ? RAM_WRITE : RAM_READ;
              mem.be    <= lane_be;
              mem.addr  <= {addr_i[ADDR_W-1:2], 2'b00};
              mem.wdata <= lane_wdata;
              st_op     <= op_i;
              st_lo     <= addr_i[1:0];
              st_word   <= addr_i[ADDR_W-1:2];
              st_dest   <= regc_addr_i;
              st_wr     <= regc_wr_i;
              tmo_cnt   <= '0;
            end
          end
        end
        S_ACCESS: begin
          if (ack_hit) begin
            mem.ce      <= RAM_DISABLE;
            mem.we      <= RAM_READ;
            wb_valid_o  <= 1'b1;
            reg_addr_o  <= st_dest;
            excp_code_o <= EXC_NONE;
            if (is_load(st_op)) begin
              reg_wr_o   <= st_wr;
              reg_data_o <= lane_load;
              if (LLSC_EN && (st_op == OP_LL)) begin
                llbit   <= SET_FLAG;
                ll_addr <= st_word;
              end
            end else if (st_op == OP_SC) begin
              reg_wr_o   <= st_wr;
              reg_data_o <= 32'd1;
              llbit      <= CLEAR_FLAG;
            end else begin
              reg_wr_o   <= 1'b0;
              reg_data_o <= '0;
              if (st_word == ll_addr) llbit <= CLEAR_FLAG;
            end
          end else if (tmo_hit) begin
            mem.ce      <= RAM_DISABLE;
            mem.we      <= RAM_READ;
            wb_valid_o  <= 1'b1;
            excp_o      <= 1'b1;
            excp_code_o <= EXC_TIMEOUT;
            reg_addr_o  <= st_dest;
            reg_wr_o    <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        default: ;
      endcase
      // Placed last so it overrides an LL set landing on the same edge.
      if (llbit_clr_i) llbit <= CLEAR_FLAG;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [5:0]  op_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [4:0]  regc_addr_i;
  logic        regc_wr_i;
  logic [31:0] regc_data_i;
  logic        llbit_clr_i;
  logic        stall_o;
  logic        wb_valid_o;
  logic [4:0]  reg_addr_o;
  logic        reg_wr_o;
  logic [31:0] reg_data_o;
  logic        excp_o;
  logic [1:0]  excp_code_o;

  mem_access_unit_if #(.ADDR_W(32)) mif ();

  mem_access_unit #(.ADDR_W(32), .TIMEOUT(4), .LLSC_EN(1'b1)) dut (
    .clk         (clk),
    .rst         (rst),
    .valid_i     (valid_i),
    .op_i        (op_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .regc_addr_i (regc_addr_i),
    .regc_wr_i   (regc_wr_i),
    .regc_data_i (regc_data_i),
    .llbit_clr_i (llbit_clr_i),
    .stall_o     (stall_o),
    .wb_valid_o  (wb_valid_o),
    .reg_addr_o  (reg_addr_o),
    .reg_wr_o    (reg_wr_o),
    .reg_data_o  (reg_data_o),
    .excp_o      (excp_o),
    .excp_code_o (excp_code_o),
    .mem         (mif)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int          ce_cnt, stall_cnt;
  logic [3:0]  cap_be;
  logic [31:0] cap_addr, cap_wdata;
  logic        cap_we;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h want=%08h", tag, got, exp);
    end
  endtask

  // Issue one instruction as the upstream stage would: hold it while stall_o,
  // answer bus requests with ack after 'waits' unacked request cycles (-1 = never).
  // Returns just after the edge that registers the WB result.
  task automatic run_op(input logic [5:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input int waits,
                        input logic [31:0] rdata);
    bit done;
    valid_i = 1'b1; op_i = op; addr_i = addr; wdata_i = wdata;
    regc_addr_i = 5'd9; regc_wr_i = 1'b1; regc_data_i = 32'hDEADBEEF;
    mif.ack = 1'b0; mif.rdata = 32'h0;
    ce_cnt = 0; stall_cnt = 0; done = 1'b0;
    cap_be = '0; cap_addr = '0; cap_wdata = '0; cap_we = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      #1;
      if (mif.ce) begin
        ce_cnt++;
        cap_be = mif.be; cap_addr = mif.addr; cap_wdata = mif.wdata; cap_we = mif.we;
        if (waits >= 0 && ce_cnt > waits) begin
          mif.ack = 1'b1; mif.rdata = rdata;
        end
      end
      #1;
      if (stall_o) stall_cnt++;
      else done = 1'b1;
      @(posedge clk); #1;
      mif.ack = 1'b0;
    end
    valid_i = 1'b0;
    if (!done) chk("cycle_budget", 32'd0, 32'd1);
    chk("wb_valid", {31'd0, wb_valid_o}, 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    rst = 1'b1; valid_i = 1'b0; op_i = '0; addr_i = '0; wdata_i = '0;
    regc_addr_i = '0; regc_wr_i = 1'b0; regc_data_i = '0; llbit_clr_i = 1'b0;
    mif.ack = 1'b0; mif.rdata = '0;
    idle(2);
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    chk("rst_wb", {31'd0, wb_valid_o}, 32'd0);
    chk("rst_ce", {31'd0, mif.ce}, 32'd0);
    chk("rst_data", reg_data_o, 32'd0);
    chk("rst_excp", {30'd0, excp_o, excp_code_o}, 32'd0);
    rst = 1'b0;
    idle(1);

    // Non-memory op: one-cycle pass-through
    run_op(6'h00, 32'h0, 32'h0, 0, 32'h0);
    chk("alu_data", reg_data_o, 32'hDEADBEEF);
    chk("alu_addr", {27'd0, reg_addr_o}, 32'd9);
    chk("alu_stall", stall_cnt, 32'd0);
    idle(1);
    chk("wb_pulse", {31'd0, wb_valid_o}, 32'd0);

    // Lb / Lbu at 0x102, lane 2 = 0xFF, three wait states
    run_op(OP_LB, 32'h102, 32'h0, 3, 32'h80FF7F01);
    chk("lb_data", reg_data_o, 32'hFFFFFFFF);
    chk("lb_stall", stall_cnt, 32'd4);
    chk("lb_ce", ce_cnt, 32'd4);
    chk("lb_addr", cap_addr, 32'h100);
    chk("lb_we", {31'd0, cap_we}, 32'd0);
    chk("lb_wr", {31'd0, reg_wr_o}, 32'd1);
    run_op(OP_LBU, 32'h102, 32'h0, 3, 32'h80FF7F01);
    chk("lbu_data", reg_data_o, 32'h000000FF);

    // Halfword loads, zero-wait memory
    run_op(OP_LH, 32'h102, 32'h0, 0, 32'h80FF7F01);
    chk("lh_data", reg_data_o, 32'hFFFF80FF);
    chk("lh_stall", stall_cnt, 32'd1);
    run_op(OP_LHU, 32'h100, 32'h0, 0, 32'h80FF7F01);
    chk("lhu_data", reg_data_o, 32'h00007F01);

    // Stores
    run_op(OP_SH, 32'h202, 32'h00001234, 1, 32'h0);
    chk("sh_be", {28'd0, cap_be}, 32'hC);
    chk("sh_wdata", cap_wdata, 32'h12341234);
    chk("sh_addr", cap_addr, 32'h200);
    chk("sh_we", {31'd0, cap_we}, 32'd1);
    chk("sh_wr", {31'd0, reg_wr_o}, 32'd0);
    run_op(OP_SB, 32'h203, 32'h000000AB, 0, 32'h0);
    chk("sb_be", {28'd0, cap_be}, 32'h8);
    chk("sb_wdata", cap_wdata, 32'hABABABAB);

    // LL then SC succeeds
    run_op(OP_LL, 32'h300, 32'h0, 0, 32'h00000055);
    chk("ll_data", reg_data_o, 32'h55);
    run_op(OP_SC, 32'h300, 32'h7, 0, 32'h0);
    chk("sc_ok_ce", ce_cnt, 32'd1);
    chk("sc_ok_be", {28'd0, cap_be}, 32'hF);
    chk("sc_ok_wdata", cap_wdata, 32'h7);
    chk("sc_ok_data", reg_data_o, 32'd1);
    chk("sc_ok_wr", {31'd0, reg_wr_o}, 32'd1);

    // Second SC without a new LL fails
    run_op(OP_SC, 32'h300, 32'h7, 0, 32'h0);
    chk("sc_again_ce", ce_cnt, 32'd0);

    // LL, intervening Sw to same word, SC fails
    run_op(OP_LL, 32'h300, 32'h0, 0, 32'h1);
    run_op(OP_SW, 32'h300, 32'h9, 0, 32'h0);
    run_op(OP_SC, 32'h300, 32'h7, 0, 32'h0);
    chk("sc_sw_ce", ce_cnt, 32'd0);
    chk("sc_sw_data", reg_data_o, 32'd0);

    // LL, llbit_clr pulse, SC fails
    run_op(OP_LL, 32'h300, 32'h0, 0, 32'h1);
    llbit_clr_i = 1'b1; idle(1); llbit_clr_i = 1'b0;
    run_op(OP_SC, 32'h300, 32'h7, 0, 32'h0);
    chk("sc_clr_ce", ce_cnt, 32'd0);
    chk("sc_clr_data", reg_data_o, 32'd0);

    // LL 0x300, SC 0x304 fails
    run_op(OP_LL, 32'h300, 32'h0, 0, 32'h1);
    run_op(OP_SC, 32'h304, 32'h7, 0, 32'h0);
    chk("sc_addr_ce", ce_cnt, 32'd0);
    chk("sc_addr_data", reg_data_o, 32'd0);

    // Misaligned accesses
    run_op(OP_LW, 32'h401, 32'h0, 0, 32'h0);
    chk("mis_ld_ce", ce_cnt, 32'd0);
    chk("mis_ld_excp", {30'd0, excp_o, excp_code_o}, {30'd0, 1'b1, EXC_MIS_LOAD});
    chk("mis_ld_wr", {31'd0, reg_wr_o}, 32'd0);
    run_op(OP_SW, 32'h402, 32'h0, 0, 32'h0);
    chk("mis_st_excp", {30'd0, excp_o, excp_code_o}, {30'd0, 1'b1, EXC_MIS_STORE});

    // Timeout: never ack
    run_op(OP_LW, 32'h500, 32'h0, -1, 32'h0);
    chk("tmo_ce", ce_cnt, 32'd4);
    chk("tmo_excp", {30'd0, excp_o, excp_code_o}, {30'd0, 1'b1, EXC_TIMEOUT});
    chk("tmo_wr", {31'd0, reg_wr_o}, 32'd0);
    idle(1);
    chk("tmo_excp_pulse", {31'd0, excp_o}, 32'd0);
    chk("tmo_code_hold", {30'd0, excp_code_o}, 32'd3);
    chk("tmo_ce_after", {31'd0, mif.ce}, 32'd0);

    // Reset in the middle of an access
    run_op(OP_LL, 32'h300, 32'h0, 0, 32'h1);
    valid_i = 1'b1; op_i = OP_LW; addr_i = 32'h600; mif.ack = 1'b0;
    idle(3);
    chk("pre_rst_ce", {31'd0, mif.ce}, 32'd1);
    rst = 1'b1; valid_i = 1'b0; #1;
    chk("rst_mid_ce", {31'd0, mif.ce}, 32'd0);
    chk("rst_mid_stall", {31'd0, stall_o}, 32'd0);
    idle(1);
    rst = 1'b0;
    idle(1);
    run_op(OP_SC, 32'h300, 32'h7, 0, 32'h0);
    chk("rst_llbit_ce", ce_cnt, 32'd0);
    chk("rst_llbit_data", reg_data_o, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
